seven_seg_scanner: RTL and testbench

Parametrised multiplexed 7-segment display driver for DIGITS common-anode digits. It generates time-multiplexed active-low anode strobes and segment patterns from a 50 MHz clock. Each digit slot has a guard (blank) interval to suppress ghosting and a PWM on-window for brightness control. Display data is double-buffered and committed only at frame boundaries. The block sits between the UART receive path (data source) and the board's display pins.

---
 rtl/seven_seg_scanner.sv | 178 +++++++++++++++++
 tb/tb_seven_seg_scanner.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode 7-segment driver: guard + PWM slot timing,
// display data double-buffered and committed on frame boundaries.
module seven_seg_scanner #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 3125,
  parameter int SLOT_W   = 4,
  parameter int GUARD    = 1
) (
  input  logic                Clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*DIGITS-1:0] digit_data,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic [DIGITS-1:0]   digit_en,
  input  logic [SLOT_W-1:0]   duty,
  output logic [DIGITS-1:0]   anode,
  output logic [6:0]          seg,
  output logic                dp_n,
  output logic                frame_start,
  output logic                pending
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = $clog2(DIGITS);
  localparam logic [SLOT_W:0] G_X = (SLOT_W+1)'(GUARD);

  typedef struct packed {
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   en;
  } disp_t;

  logic [1:0]        rst_sync_q;
  logic              rst_n;

  logic [PW-1:0]     presc_q, presc_d;
  logic [SLOT_W-1:0] phase_q, phase_d;
  logic [SLOT_W-1:0] duty_s_q, duty_s_d;
  logic [IW-1:0]     idx_q, idx_d;
  disp_t             pbuf_q, pbuf_d;
  disp_t             shadow_q, shadow_d;
  disp_t             in_w;
  logic              pend_q, pend_d;
  logic              tick, slot_end;
  logic              idx_last, boundary;

  logic [SLOT_W:0]   win_hi;
  logic              on_win, lit;
  logic [3:0]        nib;
  logic              dp_sel, en_sel;
  logic [DIGITS-1:0] anode_q, anode_d;
  logic [6:0]        seg_q, seg_d;
  logic              dpn_q, dpn_d;
  logic              fs_q;

  function automatic logic [6:0] hex_font(
    input logic [3:0] n
  );
    logic [6:0] f;
    unique case (n)
      4'h0: f = 7'b1000000;
      4'h1: f = 7'b1111001;
      4'h2: f = 7'b0100100;
      4'h3: f = 7'b0110000;
      4'h4: f = 7'b0011001;
      4'h5: f = 7'b0010010;
      4'h6: f = 7'b0000010;
      4'h7: f = 7'b1111000;
      4'h8: f = 7'b0000000;
      4'h9: f = 7'b0010000;
      4'hA: f = 7'b0001000;
      4'hB: f = 7'b0000011;
      4'hC: f = 7'b1000110;
      4'hD: f = 7'b0100001;
      4'hE: f = 7'b0000110;
      4'hF: f = 7'b0001110;
    endcase
    return f;
  endfunction

  // Async assert, release aligned to Clk through two flops.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  assign in_w     = {digit_data, dp_in, digit_en};
  assign tick     = presc_q == PW'(PRESCALE - 1);
  assign slot_end = tick && (phase_q == '1);
  assign idx_last = idx_q == IW'(DIGITS - 1);
  assign boundary = slot_end && idx_last;

  always_comb begin
    presc_d  = tick ? '0 : presc_q + PW'(1);
    phase_d  = tick ? phase_q + SLOT_W'(1) : phase_q;
    idx_d    = idx_q;
    duty_s_d = duty_s_q;
    if (slot_end) begin
      idx_d    = idx_last ? '0 : idx_q + IW'(1);
      duty_s_d = duty;
    end
    pbuf_d   = load ? in_w : pbuf_q;
    pend_d   = load ? 1'b1 : pend_q;
    shadow_d = shadow_q;
    // A load coinciding with the boundary bypasses the pending buffer.
    if (boundary) begin
      pend_d   = 1'b0;
      shadow_d = load ? in_w : (pend_q ? pbuf_q : shadow_q);
    end
  end

  // Extra bit keeps GUARD+duty from wrapping; window clips at slot end.
  assign win_hi = G_X + {1'b0, duty_s_q};
  assign on_win = ({1'b0, phase_q} >= G_X)
               && ({1'b0, phase_q} < win_hi);

  always_comb begin
    nib    = '0;
    dp_sel = 1'b0;
    en_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib    = shadow_q.data[4*i +: 4];
        dp_sel = shadow_q.dp[i];
        en_sel = shadow_q.en[i];
      end
    end
    lit     = on_win && en_sel;
    anode_d = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (lit && idx_q == IW'(i)) begin
        anode_d[i] = 1'b0;
      end
    end
    seg_d = lit ? hex_font(nib) : 7'h7f;
    dpn_d = lit ? ~dp_sel : 1'b1;
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= '0;
      phase_q  <= '0;
      idx_q    <= '0;
      duty_s_q <= '0;
      pbuf_q   <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      anode_q  <= '1;
      seg_q    <= 7'h7f;
      dpn_q    <= 1'b1;
      fs_q     <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      phase_q  <= phase_d;
      idx_q    <= idx_d;
      duty_s_q <= duty_s_d;
      pbuf_q   <= pbuf_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      anode_q  <= anode_d;
      seg_q    <= seg_d;
      dpn_q    <= dpn_d;
      fs_q     <= boundary;
    end
  end

  assign anode       = anode_q;
  assign seg         = seg_q;
  assign dp_n        = dpn_q;
  assign frame_start = fs_q;
  assign pending     = pend_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: random display data checked
// cycle-by-cycle against a frame-offset arithmetic model.
module tb_seven_seg_scanner;

  localparam int D  = 4;
  localparam int P  = 2;
  localparam int SW = 2;
  localparam int G  = 1;
  localparam int SL = 1 << SW;
  localparam int FR = P * SL * D;

  localparam logic [6:0] FONT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        Clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] digit_data;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [1:0]  duty;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame_start;
  logic        pending;

  int checks = 0;
  int passed = 0;

  logic [15:0] sd;
  logic [3:0]  sp, se;

  seven_seg_scanner #(
    .DIGITS(D), .PRESCALE(P), .SLOT_W(SW), .GUARD(G)
  ) dut (
    .Clk(Clk), .reset(reset), .load(load),
    .digit_data(digit_data), .dp_in(dp_in),
    .digit_en(digit_en), .duty(duty),
    .anode(anode), .seg(seg), .dp_n(dp_n),
    .frame_start(frame_start), .pending(pending)
  );

  always #5 Clk = ~Clk;

  wire [13:0] obs = {anode, seg, dp_n, frame_start, pending};

  // s = Clk edges since the commit edge, minus one.
  function automatic logic [12:0] model(
    input int s, input logic [15:0] d,
    input logic [3:0] dp, input logic [3:0] en,
    input int du
  );
    int tk, ph, ix;
    logic [12:0] r;
    logic [15:0] sh;
    tk = s / P;
    ph = tk % SL;
    ix = (tk / SL) % D;
    r = {4'hf, 7'h7f, 1'b1, 1'b0};
    r[0] = (s == FR - 1);
    if (ph >= G && ph < G + du && en[ix]) begin
      sh = d >> (4 * ix);
      r[12:9] = ~(4'b0001 << ix);
      r[8:2] = FONT[sh[3:0]];
      r[1] = ~dp[ix];
    end
    return r;
  endfunction

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (frame_start !== 1'b1 && n < 200);
    checks++;
    if (frame_start !== 1'b1)
      $display("FAIL wait_frame: frame_start=%b want 1", frame_start);
    else passed++;
  endtask

  task automatic commit(
    input logic [15:0] d, input logic [3:0] p,
    input logic [3:0] e
  );
    digit_data = d;
    dp_in = p;
    digit_en = e;
    load = 1'b1;
    @(negedge Clk);
    load = 1'b0;
    wait_frame();
    sd = d;
    sp = p;
    se = e;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    load = 1'b1;
    digit_data = 16'hffff;
    dp_in = 4'hf;
    digit_en = 4'hf;
    duty = 2'd3;
    repeat (3) @(negedge Clk);
    checks++;
    if (obs !== 14'b1111_1111111_1_0_0)
      $display("FAIL reset_hold: got %b want %b",
               obs, 14'b1111_1111111_1_0_0);
    else passed++;
    load = 1'b0;
    reset = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(negedge Clk);
      checks++;
      if ({obs[13:2], obs[0]} !== 13'b1111_1111111_1_0)
        $display("FAIL post_reset j=%0d: got %b want dark",
                 j, obs);
      else passed++;
    end
  endtask

  task automatic test_scan();
    logic [13:0] exp;
    int du;
    duty = 2'd3;
    commit(16'h3A70, 4'b0010, 4'b1111);
    for (int j = 1; j <= FR; j++) begin
      @(negedge Clk);
      exp = {model(j - 1, sd, sp, se, 3), 1'b0};
      checks++;
      if (obs !== exp)
        $display("FAIL scan_fixed j=%0d: got %b want %b",
                 j, obs, exp);
      else passed++;
      if (j == 12) begin
        checks++;
        if (obs[13:2] !== {4'b1101, 7'b1111000, 1'b0})
          $display("FAIL scan_digit1: got %b want %b",
                   obs[13:2], {4'b1101, 7'b1111000, 1'b0});
        else passed++;
      end
    end
    repeat (4) begin
      du = $urandom_range(0, 3);
      duty = 2'(du);
      commit(16'($urandom), 4'($urandom), 4'($urandom));
      for (int j = 1; j <= FR; j++) begin
        @(negedge Clk);
        exp = {model(j - 1, sd, sp, se, du), 1'b0};
        checks++;
        if (obs !== exp)
          $display("FAIL scan_rand j=%0d: got %b want %b",
                   j, obs, exp);
        else passed++;
      end
    end
  endtask

  task automatic test_duty();
    logic [13:0] exp;
    int lows;
    int sl_low [D];
    int du;
    duty = 2'd0;
    commit(16'h8888, 4'hf, 4'hf);
    lows = 0;
    for (int j = 1; j <= FR; j++) begin
      @(negedge Clk);
      if (anode !== 4'hf) lows++;
      exp = {model(j - 1, sd, sp, se, 0), 1'b0};
      checks++;
      if (obs !== exp)
        $display("FAIL duty0 j=%0d: got %b want %b",
                 j, obs, exp);
      else passed++;
    end
    checks++;
    if (lows !== 0)
      $display("FAIL duty0_lows: got %0d want 0", lows);
    else passed++;
    duty = 2'd3;
    wait_frame();
    for (int i = 0; i < D; i++) sl_low[i] = 0;
    for (int j = 1; j <= FR; j++) begin
      @(negedge Clk);
      if (anode !== 4'hf) sl_low[((j - 1) / P) / SL]++;
    end
    for (int i = 0; i < D; i++) begin
      checks++;
      if (sl_low[i] !== 6)
        $display("FAIL duty3_slot%0d: got %0d low want 6",
                 i, sl_low[i]);
      else passed++;
    end
    for (int j = 1; j <= FR; j++) begin
      @(negedge Clk);
      du = (((j - 1) / P) / SL == 0) ? 3 : 1;
      exp = {model(j - 1, sd, sp, se, du), 1'b0};
      checks++;
      if (obs !== exp)
        $display("FAIL duty_mid j=%0d: got %b want %b",
                 j, obs, exp);
      else passed++;
      if (j == 4) duty = 2'd1;
    end
    duty = 2'd3;
  endtask

  task automatic test_enable();
    logic [13:0] exp;
    int lo [D];
    for (int i = 0; i < D; i++) lo[i] = 0;
    commit(16'($urandom), 4'($urandom), 4'b0101);
    for (int j = 1; j <= FR; j++) begin
      @(negedge Clk);
      for (int i = 0; i < D; i++)
        if (anode[i] === 1'b0) lo[i]++;
      exp = {model(j - 1, sd, sp, se, 3), 1'b0};
      checks++;
      if (obs !== exp)
        $display("FAIL enable j=%0d: got %b want %b",
                 j, obs, exp);
      else passed++;
    end
    checks++;
    if (lo[0] !== 6 || lo[1] !== 0 || lo[2] !== 6 || lo[3] !== 0)
      $display("FAIL enable_lows: got %0d %0d %0d %0d want 6 0 6 0",
               lo[0], lo[1], lo[2], lo[3]);
    else passed++;
  endtask

  task automatic test_load();
    logic [13:0] exp;
    logic [15:0] yd, y2d, wd;
    logic [3:0]  yp, ye, y2p, y2e, wp, we;
    yd = 16'($urandom);
    yp = 4'($urandom);
    ye = 4'($urandom);
    digit_data = yd;
    dp_in = yp;
    digit_en = ye;
    load = 1'b1;
    for (int j = 1; j <= FR; j++) begin
      @(negedge Clk);
      load = 1'b0;
      exp = {model(j - 1, sd, sp, se, 3), j < FR};
      checks++;
      if (obs !== exp)
        $display("FAIL defer j=%0d: got %b want %b",
                 j, obs, exp);
      else passed++;
    end
    sd = yd;
    sp = yp;
    se = ye;
    y2d = 16'($urandom);
    y2p = 4'($urandom);
    y2e = 4'($urandom) | 4'b0100;
    digit_data = 16'($urandom);
    dp_in = 4'($urandom);
    digit_en = 4'hf;
    load = 1'b1;
    for (int j = 1; j <= FR; j++) begin
      @(negedge Clk);
      load = 1'b0;
      exp = {model(j - 1, sd, sp, se, 3), j < FR};
      checks++;
      if (obs !== exp)
        $display("FAIL defer_shown j=%0d: got %b want %b",
                 j, obs, exp);
      else passed++;
      if (j == 10) begin
        digit_data = y2d;
        dp_in = y2p;
        digit_en = y2e;
        load = 1'b1;
      end
    end
    sd = y2d;
    sp = y2p;
    se = y2e;
    wd = 16'($urandom);
    wp = 4'($urandom);
    we = 4'($urandom) | 4'b1000;
    for (int j = 1; j <= FR; j++) begin
      @(negedge Clk);
      load = 1'b0;
      exp = {model(j - 1, sd, sp, se, 3), 1'b0};
      checks++;
      if (obs !== exp)
        $display("FAIL second_load j=%0d: got %b want %b",
                 j, obs, exp);
      else passed++;
      if (j == FR - 1) begin
        digit_data = wd;
        dp_in = wp;
        digit_en = we;
        load = 1'b1;
      end
    end
    load = 1'b0;
    sd = wd;
    sp = wp;
    se = we;
    for (int j = 1; j <= FR; j++) begin
      @(negedge Clk);
      exp = {model(j - 1, sd, sp, se, 3), 1'b0};
      checks++;
      if (obs !== exp)
        $display("FAIL bypass j=%0d: got %b want %b",
                 j, obs, exp);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic [13:0] exp;
    logic [15:0] zd;
    logic [3:0]  zp, ze, fa;
    int first;
    commit(16'h1234, 4'b0000, 4'b1111);
    digit_data = 16'hBEEF;
    dp_in = 4'hf;
    digit_en = 4'hf;
    load = 1'b1;
    @(negedge Clk);
    load = 1'b0;
    repeat (3) @(negedge Clk);
    checks++;
    if (anode !== 4'b1110 || pending !== 1'b1)
      $display("FAIL pre_reset: got anode %b pend %b want 1110 1",
               anode, pending);
    else passed++;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({anode, seg, dp_n, pending} !== 13'b1111_1111111_1_0)
      $display("FAIL reset_async: got %b want dark",
               {anode, seg, dp_n, pending});
    else passed++;
    repeat (3) @(negedge Clk);
    reset = 1'b1;
    wait_frame();
    for (int j = 1; j <= FR; j++) begin
      @(negedge Clk);
      exp = {model(j - 1, 16'h0, 4'h0, 4'h0, 3), 1'b0};
      checks++;
      if (obs !== exp)
        $display("FAIL lost_pend j=%0d: got %b want %b",
                 j, obs, exp);
      else passed++;
    end
    zd = 16'($urandom);
    zp = 4'($urandom);
    ze = 4'($urandom) | 4'b0001;
    commit(zd, zp, ze);
    first = 0;
    fa = 4'hf;
    for (int j = 1; j <= FR; j++) begin
      @(negedge Clk);
      if (anode !== 4'hf && first == 0) begin
        first = j;
        fa = anode;
      end
      exp = {model(j - 1, sd, sp, se, 3), 1'b0};
      checks++;
      if (obs !== exp)
        $display("FAIL restart j=%0d: got %b want %b",
                 j, obs, exp);
      else passed++;
    end
    checks++;
    if (first !== 3 || fa !== 4'b1110)
      $display("FAIL first_strobe: got clk %0d anode %b want 3 1110",
               first, fa);
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_scan();
    test_duty();
    test_enable();
    test_load();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
